// File: rtl/lut_pkg.sv
// Shared types and sizes for the runtime-reconfigurable 6-input LUT.
package lut_pkg;

    localparam int LUT_W = 64;
    localparam int SEL_W = 6;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // O5 is the lower half of the table: force I5 low.
    function automatic logic [SEL_W-1:0] o5_addr(input logic [SEL_W-1:0] s);
        return {1'b0, s[SEL_W-2:0]};
    endfunction

endpackage

// File: rtl/lut6_rd.sv
// Active LUT table with registered O5/O6 lookup; loads the whole table
// from the shadow copy in a single cycle on commit.
module lut6_rd
    import lut_pkg::*;
#(
    parameter logic [LUT_W-1:0] INIT_RESET = 64'h0000_0000_0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_i,
    input  logic [LUT_W-1:0] shadow_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             o5_o,
    output logic             o6_o
);

    logic [LUT_W-1:0] active_q;
    logic             o5_q;
    logic             o6_q;

    // The lookup always reads the pre-commit table, so a sel in the commit
    // cycle still returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= INIT_RESET;
            o5_q     <= INIT_RESET[0];
            o6_q     <= INIT_RESET[0];
        end else begin
            if (commit_i) begin
                active_q <= shadow_i;
            end
            o6_q <= active_q[sel_i];
            o5_q <= active_q[o5_addr(sel_i)];
        end
    end

    assign o5_o = o5_q;
    assign o6_o = o6_q;

endmodule

// File: rtl/lut6_cfg_writer.sv
// Serial INIT writer for one 6-input LUT: accepts a 64-bit word, shifts it
// MSB first into a shadow table, then commits it atomically to lut6_rd.
module lut6_cfg_writer
    import lut_pkg::*;
#(
    parameter logic [LUT_W-1:0] INIT_RESET = 64'h0000_0000_0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LUT_W-1:0] cfg_data,
    input  logic [SEL_W-1:0] sel,
    output logic             o5,
    output logic             o6,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LUT_W-1:0] word_q;
    logic [LUT_W-1:0] shadow_q;
    logic [LUT_W-1:0] shadow_d;
    logic [CNT_W-1:0] bit_sel;
    logic             cfg_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             commit;

    // 63 - cnt for a 6-bit counter is its bitwise complement.
    assign bit_sel  = ~cnt_q;
    assign shadow_d = {shadow_q[LUT_W-2:0], word_q[bit_sel]};
    assign commit   = (state_q == COMMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            shadow_q    <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        word_q      <= cfg_data;
                        cnt_q       <= '0;
                        state_q     <= SHIFT;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    shadow_q <= shadow_d;
                    cnt_q    <= cnt_q + 6'd1;
                    if (cnt_q == '1) begin
                        state_q <= COMMIT;
                        done_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    lut6_rd #(
        .INIT_RESET(INIT_RESET)
    ) u_rd (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit_i (commit),
        .shadow_i (shadow_q),
        .sel_i    (sel),
        .o5_o     (o5),
        .o6_o     (o6)
    );

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lut6_cfg_writer.sv
// Bench for lut6_cfg_writer: two instances (INIT_RESET 0 and 1) share stimulus
// and are compared against a load-schedule model plus hand-derived vectors.
module tb_lut6_cfg_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [63:0] cfg_data;
    logic [5:0]  sel;
    logic        cfg_ready_0, o5_0, o6_0, busy_0, done_0;
    logic        cfg_ready_1, o5_1, o6_1, busy_1, done_1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lut6_cfg_writer #(.INIT_RESET(64'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_0),
        .cfg_data(cfg_data), .sel(sel), .o5(o5_0), .o6(o6_0), .busy(busy_0), .done(done_0)
    );

    lut6_cfg_writer #(.INIT_RESET(64'h1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_1),
        .cfg_data(cfg_data), .sel(sel), .o5(o5_1), .o6(o6_1), .busy(busy_1), .done(done_1)
    );

    // Model: an accepted word goes live 65 edges after its accept edge;
    // the writer is busy from the accept edge until that commit edge.
    int          m_e = 0;
    int          m_cat = 0;
    bit          m_pend;
    logic [63:0] m_word, m_act0, m_act1;
    logic        m_o5_0, m_o6_0, m_o5_1, m_o6_1, m_busy, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_act0 <= 64'h0;
            m_act1 <= 64'h1;
            m_o5_0 <= 1'b0;
            m_o6_0 <= 1'b0;
            m_o5_1 <= 1'b1;
            m_o6_1 <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_e    <= m_e + 1;
            m_o6_0 <= m_act0[int'(sel)];
            m_o5_0 <= m_act0[int'(sel) % 32];
            m_o6_1 <= m_act1[int'(sel)];
            m_o5_1 <= m_act1[int'(sel) % 32];
            if (m_pend && m_e == m_cat) begin
                m_act0 <= m_word;
                m_act1 <= m_word;
                m_pend <= 1'b0;
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end else if (!m_pend && cfg_valid) begin
                m_pend <= 1'b1;
                m_word <= cfg_data;
                m_cat  <= m_e + 65;
                m_busy <= 1'b1;
                m_done <= 1'b0;
            end else begin
                m_done <= m_pend && (m_e + 1 == m_cat);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t sel=%h)", name, act, exp, $time, sel);
        end
    endtask

    task automatic cmp_model();
        chk("m_o5_0", o5_0, m_o5_0);
        chk("m_o6_0", o6_0, m_o6_0);
        chk("m_o5_1", o5_1, m_o5_1);
        chk("m_o6_1", o6_1, m_o6_1);
        chk("m_ready", cfg_ready_0, !m_busy);
        chk("m_busy", busy_0, m_busy);
        chk("m_done", done_0, m_done);
        chk("m_ready1", cfg_ready_1, !m_busy);
        chk("m_busy1", busy_1, m_busy);
        chk("m_done1", done_1, m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    // Load one word; j counts edges after the accept edge T0.
    task automatic do_load(input logic [63:0] w, input bit hold);
        chk("ready_pre", cfg_ready_0, 1'b1);
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        chk("ready_acc", cfg_ready_0, 1'b0);
        chk("busy_acc", busy_0, 1'b1);
        if (!hold) begin
            cfg_valid = 1'b0;
            cfg_data  = ~w;
        end
        for (int j = 1; j <= 65; j++) begin
            tick();
            chk("done_t", done_0, j == 64);
            chk("ready_t", cfg_ready_0, j == 65);
            chk("busy_t", busy_0, j != 65);
        end
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0] word;
        bit          hold;
        logic [5:0]  sel;
        logic        o5;
        logic        o6;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_0000_0000, 1'b0, 6'h20, 1'b0, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_0000_0000, 1'b0, 6'h00, 1'b0, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_CA00, 1'b1, 6'h09, 1'b1, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_CA00, 1'b1, 6'h08, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0001, 1'b0, 6'h3F, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0001, 1'b0, 6'h00, 1'b1, 1'b1};
        vecs[6] = '{64'h0000_0001_8000_0000, 1'b0, 6'h1F, 1'b1, 1'b1};
        vecs[7] = '{64'h0000_0001_8000_0000, 1'b0, 6'h20, 1'b0, 1'b1};
        vecs[8] = '{64'h1234_5678_9ABC_DEF0, 1'b0, 6'h04, 1'b1, 1'b1};
        vecs[9] = '{64'h1234_5678_9ABC_DEF0, 1'b0, 6'h23, 1'b0, 1'b1};

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        sel       = '0;
        repeat (2) @(negedge clk);
        cmp_model();
        chk("rst_o5", o5_0, 1'b0);
        chk("rst_o6", o6_0, 1'b0);
        chk("rst_ready", cfg_ready_0, 1'b1);
        chk("rst_busy", busy_0, 1'b0);
        chk("rst_done", done_0, 1'b0);
        chk("rst_o6_init1", o6_1, 1'b1);
        rst_n = 1'b1;

        for (int s = 0; s < 64; s++) begin
            sel = 6'(s);
            tick();
            chk("sweep_o6", o6_0, 1'b0);
            chk("sweep_o6_init1", o6_1, s == 0);
        end

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].word, vecs[i].hold);
            sel = vecs[i].sel;
            tick();
            chk("vec_o5", o5_0, vecs[i].o5);
            chk("vec_o6", o6_0, vecs[i].o6);
        end

        // Lookups keep serving the old table through the commit cycle.
        do_load(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 64'h5555_5555_5555_5555;
        for (int j = 0; j <= 70; j++) begin
            logic [5:0] cur;
            cur = 6'($urandom);
            sel = cur;
            tick();
            if (j == 0) cfg_valid = 1'b0;
            chk("iso_o6", o6_0, (j <= 65) ? cur[0] : ~cur[0]);
        end

        // Back-to-back: second word offered while the first commits.
        cfg_valid = 1'b1;
        cfg_data  = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        for (int j = 1; j <= 131; j++) begin
            if (j == 65) cfg_data = 64'hF0F0_F0F0_F0F0_F0F0;
            tick();
            if (j == 66) cfg_valid = 1'b0;
            chk("b2b_done", done_0, (j == 64) || (j == 130));
            chk("b2b_ready", cfg_ready_0, (j == 65) || (j == 131));
        end
        sel = 6'h04;
        tick();
        chk("b2b_o6", o6_0, 1'b1);

        for (int c = 0; c < 600; c++) begin
            sel       = 6'($urandom);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_data  = {$urandom, $urandom};
            tick();
        end
        cfg_valid = 1'b0;
        repeat (70) tick();

        // Reset in the middle of a load.
        cfg_valid = 1'b1;
        cfg_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        cfg_valid = 1'b0;
        repeat (29) tick();
        #2 rst_n = 1'b0;
        #1;
        cmp_model();
        chk("mid_rst_busy", busy_0, 1'b0);
        chk("mid_rst_busy1", busy_1, 1'b0);
        chk("mid_rst_ready", cfg_ready_0, 1'b1);
        chk("mid_rst_o6_1", o6_1, 1'b1);
        chk("mid_rst_o6_0", o6_0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 6'h00;
        tick();
        chk("post_rst_sel0", o6_1, 1'b1);
        sel = 6'h01;
        tick();
        chk("post_rst_sel1", o6_1, 1'b0);
        sel = 6'h3F;
        tick();
        chk("post_rst_dut0", o6_0, 1'b0);
        repeat (70) tick();
        chk("post_rst_no_commit", o6_0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
